// File: rtl/io_bus_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_pkg
//   Shared definitions for the IO/debug read bus initiator: default bus
//   widths, the read latency of the cpu_top IO read path, the default output
//   FIFO depth and the sweep FSM state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package io_bus_pkg;

   localparam int IO_ADDR_W     = 8;
   localparam int IO_DATA_W     = 8;
   localparam int IO_RD_LAT     = 1;
   localparam int IO_FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/io_fifo.sv
// ---------------------------------------------------------------------------
// io_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is always
//   visible on rdata_o while the FIFO is not empty. A push into a full FIFO
//   is accepted when a pop happens in the same cycle.
// Ports
//   clk_i     in   1        clock, rising edge
//   reset_ni  in   1        asynchronous reset, active-low
//   push_i    in   1        write wdata_i this cycle
//   wdata_i   in   WIDTH    write data
//   pop_i     in   1        drop the head entry this cycle
//   rdata_o   out  WIDTH    head entry
//   full_o    out  1        all DEPTH entries occupied
//   empty_o   out  1        no entries
//   level_o   out  log2+1   number of occupied entries
// ---------------------------------------------------------------------------
module io_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [LVL_W-1:0] level_q;
   logic             doPush;
   logic             doPop;

   // A pop frees the slot a simultaneous push needs, so full only blocks a
   // push that has no pop alongside it.
   assign doPop  = pop_i && (level_q != '0);
   assign doPush = push_i && ((level_q != LVL_W'(DEPTH)) || doPop);

   assign rdata_o = mem_q[rdPtr_q];
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

   // Storage, pointers and occupancy. Storage is cleared on reset so the
   // head output reads zero straight out of reset. Pointers wrap naturally
   // because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
            wrPtr_q        <= wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         case ({doPush, doPop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/io_bus_reader.sv
// ---------------------------------------------------------------------------
// io_bus_reader
//   Initiator side of the CPU debug/IO read bus. On start it sweeps COUNT
//   consecutive addresses from BASE, waits RD_LAT cycles after every address
//   change before sampling io_bus_dout, and queues {addr,data} pairs in an
//   output FIFO that drains over a valid/ready stream.
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous reset, active-low
//   start        in   1       sweep request, honoured only when idle
//   base_addr    in   ADDR_W  first address of the sweep
//   count        in   ADDR_W  number of reads, 0 means 2**ADDR_W
//   busy         out  1       sweep in progress (through the done cycle)
//   done         out  1       one-cycle pulse, sweep finished and FIFO empty
//   io_bus_addr  out  ADDR_W  address presented to cpu_top
//   io_bus_dout  in   DATA_W  read data from cpu_top
//   m_valid      out  1       stream word available
//   m_ready      in   1       consumer accepts the word
//   m_addr       out  ADDR_W  address of the head word
//   m_data       out  DATA_W  data of the head word
// ---------------------------------------------------------------------------
module io_bus_reader
   import io_bus_pkg::*;
#(
   parameter int ADDR_W     = IO_ADDR_W,
   parameter int DATA_W     = IO_DATA_W,
   parameter int RD_LAT     = IO_RD_LAT,
   parameter int FIFO_DEPTH = IO_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] io_bus_addr,
   input  logic [DATA_W-1:0] io_bus_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data
);

   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int WORD_W = ADDR_W + DATA_W;

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W:0]    remain_q;
   logic [LAT_W-1:0]   latCnt_q;
   logic               busy_q;
   logic               done_q;

   logic               fifoFull;
   logic               fifoEmpty;
   logic [LVL_W-1:0]   fifoLevel;
   logic [WORD_W-1:0]  headWord;
   logic               popEn;
   logic               pushEn;
   logic               drainDone;

   // The consumer may drain at any time; a capture can land in a full FIFO
   // only when the head leaves in the same cycle.
   assign popEn     = !fifoEmpty && m_ready;
   assign pushEn    = (state_q == ST_CAPTURE) && (!fifoFull || popEn);
   assign drainDone = (fifoLevel == '0) || ((fifoLevel == LVL_W'(1)) && popEn);

   // Sweep FSM with registered outputs. The remaining counter is one bit
   // wider than the address so a count of zero can stand for a full
   // 2**ADDR_W sweep. The address only moves after a successful capture,
   // which keeps it stable through every settle and stalled capture cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         latCnt_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q   <= base_addr;
                  remain_q <= (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, count};
                  latCnt_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               latCnt_q <= latCnt_q + LAT_W'(1);
               if (latCnt_q == LAT_W'(RD_LAT - 1)) begin
                  state_q <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (pushEn) begin
                  remain_q <= remain_q - (ADDR_W+1)'(1);
                  if (remain_q == (ADDR_W+1)'(1)) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     addr_q   <= addr_q + ADDR_W'(1);
                     latCnt_q <= '0;
                     state_q  <= ST_SETTLE;
                  end
               end
            end
            ST_DRAIN: begin
               if (drainDone) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   io_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk_i    (clk),
      .reset_ni (reset),
      .push_i   (pushEn),
      .wdata_i  ({addr_q, io_bus_dout}),
      .pop_i    (popEn),
      .rdata_o  (headWord),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty),
      .level_o  (fifoLevel)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign io_bus_addr = addr_q;
   assign m_valid     = !fifoEmpty;
   assign m_addr      = headWord[WORD_W-1 -: ADDR_W];
   assign m_data      = headWord[DATA_W-1:0];

endmodule
